// File: rtl/intra_4x4_mode_pe.sv
// intra_4x4_mode_pe: H.264 Intra4x4 mode decision for one 4x4 luma block.
// Evaluates Vertical, Horizontal and DC prediction with one shared SAD
// datapath (one mode per cycle). It then picks the cheapest eligible mode and
// emits that mode, its prediction block and the residual block.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   h264_reset          synchronous frame-level clear, highest priority
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   top, left           neighbours A..D and I..L; top_avail/left_avail qualify them
//   cur_blk             original samples, [row][col]
//   out_valid/out_ready output handshake; outputs held while stalled
//   best_mode           0 = V, 1 = H, 2 = DC
//   best_sad            SAD of the chosen mode, including MODE_COST for V/H
//   pred_blk            prediction block of the chosen mode
//   res_blk             cur_blk - pred_blk, two's complement per sample
module intra_4x4_mode_pe #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned VH_EN     = 1,
    parameter int unsigned MODE_COST = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 h264_reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [3:0][BIT_DEPTH-1:0]            top,
    input  logic [3:0][BIT_DEPTH-1:0]            left,
    input  logic                                 top_avail,
    input  logic                                 left_avail,
    input  logic [3:0][3:0][BIT_DEPTH-1:0]       cur_blk,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [1:0]                           best_mode,
    output logic [BIT_DEPTH+4:0]                 best_sad,
    output logic [3:0][3:0][BIT_DEPTH-1:0]       pred_blk,
    output logic signed [3:0][3:0][BIT_DEPTH:0]  res_blk
);

    localparam int unsigned BD = BIT_DEPTH;
    localparam int unsigned SW = BIT_DEPTH + 5;
    localparam int unsigned RW = BIT_DEPTH + 1;
    localparam int unsigned DW = BIT_DEPTH + 3;

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL_V, S_EVAL_H, S_EVAL_DC, S_BUILD, S_OUT
    } state_t;

    state_t state, next_state;

    logic [3:0][BD-1:0]             top_q;
    logic [3:0][BD-1:0]             left_q;
    logic                           top_av_q;
    logic                           left_av_q;
    logic [3:0][3:0][BD-1:0]        cur_q;
    logic [SW-1:0]                  sad_v_q;
    logic [SW-1:0]                  sad_h_q;
    logic [SW-1:0]                  sad_dc_q;

    logic [DW-1:0]                  sum_top;
    logic [DW-1:0]                  sum_left;
    logic [DW-1:0]                  dc_sum;
    logic [BD-1:0]                  dc_c;
    logic                           v_ok;
    logic                           h_ok;
    logic [1:0]                     dec_mode_c;
    logic [SW-1:0]                  best_c;
    logic [1:0]                     mode_sel;
    logic [3:0][3:0][BD-1:0]        pred_c;
    logic signed [3:0][3:0][RW-1:0] res_c;
    logic [RW-1:0]                  absd;
    logic [SW-1:0]                  sad_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the frame-level clear overrides any handshake
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = S_EVAL_V;
            end
            S_EVAL_V:  next_state = S_EVAL_H;
            S_EVAL_H:  next_state = S_EVAL_DC;
            S_EVAL_DC: next_state = S_BUILD;
            S_BUILD:   next_state = S_OUT;
            S_OUT:     if (out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (h264_reset) next_state = S_IDLE;
    end

    // DC predictor from the registered neighbours
    always_comb begin
        sum_top  = '0;
        sum_left = '0;
        for (int i = 0; i < 4; i++) begin
            sum_top  = sum_top  + DW'(top_q[i]);
            sum_left = sum_left + DW'(left_q[i]);
        end
        dc_sum = '0;
        dc_c   = {1'b1, {(BD-1){1'b0}}};
        if (top_av_q && left_av_q) begin
            dc_sum = sum_top + sum_left + DW'(4);
            dc_c   = BD'(dc_sum >> 3);
        end else if (top_av_q) begin
            dc_sum = sum_top + DW'(2);
            dc_c   = BD'(dc_sum >> 2);
        end else if (left_av_q) begin
            dc_sum = sum_left + DW'(2);
            dc_c   = BD'(dc_sum >> 2);
        end
    end

    assign v_ok = (VH_EN != 0) && top_av_q;
    assign h_ok = (VH_EN != 0) && left_av_q;

    // Mode decision: H is checked before V with <= so ties fall to the lower mode
    always_comb begin
        dec_mode_c = MODE_DC;
        best_c     = sad_dc_q;
        if (h_ok && (sad_h_q <= best_c)) begin
            dec_mode_c = MODE_H;
            best_c     = sad_h_q;
        end
        if (v_ok && (sad_v_q <= best_c)) begin
            dec_mode_c = MODE_V;
            best_c     = sad_v_q;
        end
    end

    // Mode currently driven through the shared predictor/SAD datapath
    always_comb begin
        unique case (state)
            S_EVAL_V: mode_sel = MODE_V;
            S_EVAL_H: mode_sel = MODE_H;
            S_BUILD:  mode_sel = dec_mode_c;
            default:  mode_sel = MODE_DC;
        endcase
    end

    // Shared predictor, residual and SAD for the selected mode
    always_comb begin
        absd  = '0;
        sad_c = (mode_sel == MODE_DC) ? '0 : SW'(MODE_COST);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                unique case (mode_sel)
                    MODE_V:  pred_c[r][c] = top_q[c];
                    MODE_H:  pred_c[r][c] = left_q[r];
                    default: pred_c[r][c] = dc_c;
                endcase
                res_c[r][c] = RW'(cur_q[r][c]) - RW'(pred_c[r][c]);
                absd  = res_c[r][c][RW-1] ? (~res_c[r][c] + 1'b1) : res_c[r][c];
                sad_c = sad_c + SW'(absd);
            end
        end
    end

    // Block capture, per-mode SAD registers and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q     <= '0;
            left_q    <= '0;
            top_av_q  <= 1'b0;
            left_av_q <= 1'b0;
            cur_q     <= '0;
            sad_v_q   <= '0;
            sad_h_q   <= '0;
            sad_dc_q  <= '0;
            out_valid <= 1'b0;
            best_mode <= '0;
            best_sad  <= '0;
            pred_blk  <= '0;
            res_blk   <= '0;
        end else if (h264_reset) begin
            top_q     <= '0;
            left_q    <= '0;
            top_av_q  <= 1'b0;
            left_av_q <= 1'b0;
            cur_q     <= '0;
            sad_v_q   <= '0;
            sad_h_q   <= '0;
            sad_dc_q  <= '0;
            out_valid <= 1'b0;
            best_mode <= '0;
            best_sad  <= '0;
            pred_blk  <= '0;
            res_blk   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        top_q     <= top;
                        left_q    <= left;
                        top_av_q  <= top_avail;
                        left_av_q <= left_avail;
                        cur_q     <= cur_blk;
                    end
                end
                S_EVAL_V:  sad_v_q  <= sad_c;
                S_EVAL_H:  sad_h_q  <= sad_c;
                S_EVAL_DC: sad_dc_q <= sad_c;
                S_BUILD: begin
                    best_mode <= dec_mode_c;
                    best_sad  <= best_c;
                    pred_blk  <= pred_c;
                    res_blk   <= res_c;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intra_4x4_mode_pe.sv
// Testbench for intra_4x4_mode_pe: two instances (MODE_COST 0 and 1) share
// stimulus; expected results come from a behavioural model and are checked by
// a scoreboard monitor whenever out_valid is high.
module tb_intra_4x4_mode_pe;

    localparam int unsigned BD = 8;

    typedef struct {
        logic [1:0]            mode;
        logic [12:0]           sad;
        logic [3:0][3:0][7:0]  pred;
        logic [3:0][3:0][8:0]  res;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, h264_reset, in_valid, out_ready;
    logic [3:0][7:0]       top_p, left_p;
    logic                  ta, la;
    logic [3:0][3:0][7:0]  cur_p;

    logic                  in_ready0, out_valid0, in_ready1, out_valid1;
    logic [1:0]            best_mode0, best_mode1;
    logic [12:0]           best_sad0, best_sad1;
    logic [3:0][3:0][7:0]  pred0, pred1;
    logic [3:0][3:0][8:0]  res0, res1;

    intra_4x4_mode_pe #(.BIT_DEPTH(8), .VH_EN(1), .MODE_COST(0)) dut0 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset),
        .in_valid(in_valid), .in_ready(in_ready0),
        .top(top_p), .left(left_p), .top_avail(ta), .left_avail(la),
        .cur_blk(cur_p), .out_valid(out_valid0), .out_ready(out_ready),
        .best_mode(best_mode0), .best_sad(best_sad0),
        .pred_blk(pred0), .res_blk(res0)
    );

    intra_4x4_mode_pe #(.BIT_DEPTH(8), .VH_EN(1), .MODE_COST(1)) dut1 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset),
        .in_valid(in_valid), .in_ready(in_ready1),
        .top(top_p), .left(left_p), .top_avail(ta), .left_avail(la),
        .cur_blk(cur_p), .out_valid(out_valid1), .out_ready(out_ready),
        .best_mode(best_mode1), .best_sad(best_sad1),
        .pred_blk(pred1), .res_blk(res1)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    int   t_a[4];
    int   l_a[4];
    int   cur_a[4][4];
    bit   ta_a, la_a;

    function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: compute every mode's prediction and SAD, keep the cheapest eligible one
    function automatic exp_t model(input int cost);
        exp_t e;
        int   dc, st, sl, best, p;
        int   sad[3];
        bit   ok[3];
        st = 0; sl = 0;
        for (int i = 0; i < 4; i++) begin
            st += t_a[i];
            sl += l_a[i];
        end
        if (ta_a && la_a) dc = (st + sl + 4) / 8;
        else if (ta_a)    dc = (st + 2) / 4;
        else if (la_a)    dc = (sl + 2) / 4;
        else              dc = 1 << (BD - 1);
        ok[0] = ta_a; ok[1] = la_a; ok[2] = 1'b1;
        sad[0] = cost; sad[1] = cost; sad[2] = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                sad[0] += iabs(cur_a[r][c] - t_a[c]);
                sad[1] += iabs(cur_a[r][c] - l_a[r]);
                sad[2] += iabs(cur_a[r][c] - dc);
            end
        best = -1;
        e.mode = 2'd2;
        for (int m = 0; m < 3; m++)
            if (ok[m] && (best < 0 || sad[m] < best)) begin
                best   = sad[m];
                e.mode = 2'(m);
            end
        e.sad = 13'(best);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                p = (e.mode == 2'd0) ? t_a[c] : (e.mode == 2'd1) ? l_a[r] : dc;
                e.pred[r][c] = 8'(p);
                e.res[r][c]  = 9'(cur_a[r][c] - p);
            end
        return e;
    endfunction

    task automatic drive_ports();
        for (int i = 0; i < 4; i++) begin
            top_p[i]  = 8'(t_a[i]);
            left_p[i] = 8'(l_a[i]);
        end
        ta = ta_a;
        la = la_a;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cur_p[r][c] = 8'(cur_a[r][c]);
    endtask

    // Offer the block until accepted; called and returning at posedge+1
    task automatic send(output int waits);
        drive_ports();
        in_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready0 && waits < 40);
        chk("accept", 160'(in_ready0), 160'(1));
        q0.push_back(model(0));
        q1.push_back(model(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen
    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid0 && k < 20);
        chk("out_valid_seen", 160'(out_valid0), 160'(1));
    endtask

    task automatic drain(input bit bp);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 160'(q0.size() + q1.size()), 160'(0));
        out_ready = 1'b1;
    endtask

    task automatic run_dir(input string nm, input logic [1:0] m0, input logic [1:0] m1, output int lat);
        int w;
        send(w);
        wait_valid(lat);
        chk({nm, "_mode_c0"}, 160'(best_mode0), 160'(m0));
        chk({nm, "_mode_c1"}, 160'(best_mode1), 160'(m1));
        @(posedge clk); #1;
        drain(1'b0);
    endtask

    task automatic fill(input int tv, input int lv, input bit tav, input bit lav, input int cv);
        for (int i = 0; i < 4; i++) begin
            t_a[i] = tv;
            l_a[i] = lv;
        end
        ta_a = tav; la_a = lav;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cur_a[r][c] = cv;
    endtask

    task automatic gen_random();
        int kind, k, v;
        kind = int'($urandom_range(0, 4));
        k    = int'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            t_a[i] = (kind == 3) ? k : int'($urandom_range(0, 255));
            l_a[i] = (kind == 3) ? k : int'($urandom_range(0, 255));
        end
        ta_a = 1'($urandom_range(0, 1));
        la_a = 1'($urandom_range(0, 1));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                case (kind)
                    0:       v = t_a[c];
                    1:       v = l_a[r];
                    2, 3:    v = k;
                    default: v = int'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 1) == 1) v = v + int'($urandom_range(0, 6)) - 3;
                cur_a[r][c] = (v < 0) ? 0 : (v > 255) ? 255 : v;
            end
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_out_valid"}, 160'(out_valid0), 160'(0));
        chk({nm, "_out_valid_c1"}, 160'(out_valid1), 160'(0));
        chk({nm, "_in_ready"}, 160'(in_ready0), 160'(1));
        chk({nm, "_in_ready_c1"}, 160'(in_ready1), 160'(1));
        chk({nm, "_best_mode"}, 160'(best_mode0), 160'(0));
        chk({nm, "_best_sad"}, 160'(best_sad0), 160'(0));
        chk({nm, "_pred_blk"}, 160'(pred0), 160'(0));
        chk({nm, "_res_blk"}, 160'(res0), 160'(0));
    endtask

    // Scoreboard monitor: outputs must match the oldest expectation on every valid cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_output_c0", 160'(out_valid0), 160'(0));
                end else begin
                    chk("mode_c0", 160'(best_mode0), 160'(q0[0].mode));
                    chk("sad_c0", 160'(best_sad0), 160'(q0[0].sad));
                    chk("pred_c0", 160'(pred0), 160'(q0[0].pred));
                    chk("res_c0", 160'(res0), 160'(q0[0].res));
                    if (out_ready) void'(q0.pop_front());
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_output_c1", 160'(out_valid1), 160'(0));
                end else begin
                    chk("mode_c1", 160'(best_mode1), 160'(q1[0].mode));
                    chk("sad_c1", 160'(best_sad1), 160'(q1[0].sad));
                    chk("pred_c1", 160'(pred1), 160'(q1[0].pred));
                    chk("res_c1", 160'(res1), 160'(q1[0].res));
                    if (out_ready) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w, seen;
        rst = 1'b0; h264_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fill(0, 0, 1'b0, 1'b0, 0);
        drive_ports();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // No neighbours, flat block: DC = 128, zero residual, latency
        fill(0, 0, 1'b0, 1'b0, 128);
        run_dir("flat_dc", 2'd2, 2'd2, lat);
        chk("latency_edges", 160'(lat), 160'(5));

        // Vertical gradient matches the top row exactly
        fill(0, 0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) t_a[i] = 10 * (i + 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cur_a[r][c] = t_a[c];
        run_dir("vert", 2'd0, 2'd0, lat);

        // Horizontal rows, top unavailable; then no neighbours at all
        fill(0, 0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) l_a[i] = 50 + 10 * i;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cur_a[r][c] = l_a[r];
        run_dir("horiz", 2'd1, 2'd1, lat);
        la_a = 1'b0;
        run_dir("horiz_noavail", 2'd2, 2'd2, lat);

        // Three-way tie; MODE_COST biases the second instance to DC
        fill(100, 100, 1'b1, 1'b1, 100);
        run_dir("tie", 2'd0, 2'd2, lat);

        // Backpressure: outputs held, no acceptance while stalled
        out_ready = 1'b0;
        gen_random();
        send(w);
        wait_valid(lat);
        for (int i = 0; i < 7; i++) begin
            chk("stall_in_ready", 160'(in_ready0), 160'(0));
            chk("stall_out_valid", 160'(out_valid0), 160'(1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        gen_random();
        out_ready = 1'b1;
        send(w);
        chk("accept_after_release", 160'(w), 160'(2));
        wait_valid(lat);
        @(posedge clk); #1;
        drain(1'b0);

        // Frame-level clear while presenting a result
        out_ready = 1'b0;
        gen_random();
        send(w);
        wait_valid(lat);
        @(posedge clk); #1;
        h264_reset = 1'b1;
        @(posedge clk); #1;
        h264_reset = 1'b0;
        q0.delete();
        q1.delete();
        check_cleared("h264_reset");
        out_ready = 1'b1;

        // Asynchronous reset during EVAL_H aborts the block
        fill(200, 30, 1'b1, 1'b1, 7);
        send(w);
        wait_valid(lat);
        @(posedge clk); #1;
        drain(1'b0);
        gen_random();
        send(w);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        check_cleared("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen = 1;
        end
        chk("no_output_after_abort", 160'(seen), 160'(0));
        @(posedge clk); #1;

        // Random blocks with random backpressure
        for (int n = 0; n < 200; n++) begin
            gen_random();
            send(w);
            drain(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
